mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_if.sv | 23 ++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Memory-side bus between the load/store unit and the data memory.
// The unit drives the request side; memory returns ack and read data.
interface mem_access_if #(
    parameter int NB_DATA = 32
);
    logic               mem_req_o;
    logic               mem_we_o;
    logic [NB_DATA-1:0] mem_addr_o;
    logic [3:0]         mem_be_o;
    logic [NB_DATA-1:0] mem_wdata_o;
    logic               mem_ack_i;
    logic [NB_DATA-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding access, lane steering,
// load extension, misalignment pulse and a sticky ack timeout.
module mem_access_unit #(
    parameter int NB_DATA = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               op_valid_i,
    input  logic [5:0]         mem_signals_i,
    input  logic [NB_DATA-1:0] addr_i,
    input  logic [NB_DATA-1:0] wr_data_i,
    mem_access_if.master       mem,
    output logic               stall_o,
    output logic [NB_DATA-1:0] load_data_o,
    output logic               load_valid_o,
    output logic               misalign_o,
    output logic               error_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t state_q, state_d;

    logic [NB_DATA-1:0] addr_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [NB_DATA-1:0] wdata_q;
    logic [7:0]         cnt_q;

    logic               is_op, aligned, accept, misal;
    logic               timeout;
    logic [3:0]         be_d;
    logic [NB_DATA-1:0] wdata_d;
    logic [7:0]         ld_b;
    logic [15:0]        ld_h;
    logic [NB_DATA-1:0] ld_ext;
    logic               in_access;
    logic               unused_rsv;

    assign unused_rsv = mem_signals_i[5];
    assign in_access  = (state_q == ACCESS);

    assign is_op = op_valid_i & (mem_signals_i[0] | mem_signals_i[1]);

    always_comb begin
        aligned = 1'b1;
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = NB_DATA'({4{wr_data_i[7:0]}});
        unique case (1'b1)
            mem_signals_i[3]: begin
                aligned = (addr_i[1:0] == 2'b00);
                be_d    = 4'b1111;
                wdata_d = wr_data_i;
            end
            (mem_signals_i[3:2] == 2'b01): begin
                aligned = ~addr_i[0];
                be_d    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_d = NB_DATA'({2{wr_data_i[15:0]}});
            end
            default: ;
        endcase
    end

    assign accept = (state_q == IDLE) & is_op & aligned;
    assign misal  = (state_q == IDLE) & is_op & ~aligned;

    // Little-endian lane pick from the latched byte offset
    always_comb begin
        ld_b   = mem.mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        ld_h   = mem.mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        ld_ext = {{(NB_DATA-8){~uns_q & ld_b[7]}}, ld_b};
        unique case (1'b1)
            size_q[1]:            ld_ext = mem.mem_rdata_i;
            (size_q == 2'b01):    ld_ext = {{(NB_DATA-16){~uns_q & ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        unique case (state_q)
            IDLE:   if (accept) state_d = ACCESS;
            ACCESS: begin
                if (mem.mem_ack_i) begin
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    timeout = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_o         = accept | in_access;
    assign mem.mem_req_o   = in_access;
    assign mem.mem_we_o    = in_access & we_q;
    assign mem.mem_addr_o  = in_access ? {addr_q[NB_DATA-1:2], 2'b00} : '0;
    assign mem.mem_be_o    = in_access ? be_q : 4'b0000;
    assign mem.mem_wdata_o = in_access ? wdata_q : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            wdata_q      <= '0;
            cnt_q        <= 8'd0;
            load_data_o  <= '0;
            load_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            state_q      <= state_d;
            misalign_o   <= misal;
            load_valid_o <= 1'b0;
            if (accept) begin
                addr_q  <= addr_i;
                size_q  <= mem_signals_i[3:2];
                uns_q   <= mem_signals_i[4];
                we_q    <= mem_signals_i[1];
                be_q    <= be_d;
                wdata_q <= wdata_d;
                cnt_q   <= 8'd0;
            end
            if (in_access & ~mem.mem_ack_i)
                cnt_q <= cnt_q + 8'd1;
            if (in_access & mem.mem_ack_i & ~we_q) begin
                load_data_o  <= ld_ext;
                load_valid_o <= 1'b1;
            end
            // A timed-out load still retires, with a zero result
            if (timeout) begin
                error_o      <= 1'b1;
                load_data_o  <= '0;
                load_valid_o <= ~we_q;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, random ops vs. a
// lane-arithmetic model, timeout, reset-in-access and stray-ack cases.
module tb_mem_access_unit;
    localparam int NB = 32;
    localparam int TO = 255;

    logic          clock = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [5:0]    mem_signals;
    logic [NB-1:0] addr;
    logic [NB-1:0] wr_data;
    logic          stall_o;
    logic [NB-1:0] load_data_o;
    logic          load_valid_o;
    logic          misalign_o;
    logic          error_o;

    int vectors = 0;
    int miscompares = 0;

    mem_access_if #(.NB_DATA(NB)) mem_bus ();

    mem_access_unit #(.NB_DATA(NB), .TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid_i   (op_valid),
        .mem_signals_i(mem_signals),
        .addr_i       (addr),
        .wr_data_i    (wr_data),
        .mem          (mem_bus),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misalign_o   (misalign_o),
        .error_o      (error_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  sig;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;
        bit          mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_aligned(input logic [31:0] a, input logic [1:0] sz);
        if (sz >= 2) return (a % 4) == 0;
        if (sz == 1) return (a % 2) == 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz >= 2) return 4'd15;
        if (sz == 1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        return 4'(1 << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz >= 2) return d;
        if (sz == 1) return (d % 65536) * 32'h0001_0001;
        return (d % 256) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] r, input logic [31:0] a,
                                           input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        if (sz >= 2) return r;
        if (sz == 1) begin
            v = (r / (((a % 4) >= 2) ? 32'h1_0000 : 32'h1)) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = (r >> (8 * (a % 4))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        bit rd_op;
        int stalls;
        rd_op = v.sig[0] & ~v.sig[1];
        @(posedge clock); #1;
        op_valid = 1'b1; mem_signals = v.sig; addr = v.addr; wr_data = v.wd;
        @(negedge clock);
        if (v.sig[1:0] == 2'b00) begin
            check("nop_stall", stall_o, 0);
            @(posedge clock); #1 op_valid = 1'b0;
            @(negedge clock);
            check("nop_req", mem_bus.mem_req_o, 0);
            check("nop_mis", misalign_o, 0);
            return;
        end
        if (v.mis) begin
            check("mis_stall", stall_o, 0);
            @(posedge clock); #1 op_valid = 1'b0;
            @(negedge clock);
            check("mis_pulse", misalign_o, 1);
            check("mis_req", mem_bus.mem_req_o, 0);
            check("mis_stall2", stall_o, 0);
            @(posedge clock); #1;
            @(negedge clock);
            check("mis_width", misalign_o, 0);
            check("mis_req2", mem_bus.mem_req_o, 0);
            return;
        end
        stalls = int'(stall_o);
        for (int k = 1; k <= v.delay; k++) begin
            @(posedge clock); #1;
            mem_bus.mem_ack_i   = (k == v.delay);
            mem_bus.mem_rdata_i = (k == v.delay) ? v.rdata : $urandom;
            @(negedge clock);
            stalls += int'(stall_o);
            check("acc_req", mem_bus.mem_req_o, 1);
            check("acc_addr", mem_bus.mem_addr_o, v.addr & 32'hFFFF_FFFC);
            check("acc_be", mem_bus.mem_be_o, v.be);
            check("acc_we", mem_bus.mem_we_o, !rd_op);
            if (!rd_op) check("acc_wdata", mem_bus.mem_wdata_o, v.wdata);
        end
        @(posedge clock); #1;
        mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = $urandom;
        @(negedge clock);
        check("done_stall", stall_o, 0);
        check("done_req", mem_bus.mem_req_o, 0);
        check("done_lvalid", load_valid_o, rd_op);
        if (rd_op) check("done_ldata", load_data_o, v.ld);
        check("stall_cycles", stalls, v.delay + 1);
        @(posedge clock); #1 op_valid = 1'b0;
        @(negedge clock);
        check("idle_lvalid", load_valid_o, 0);
        check("no_reaccept", mem_bus.mem_req_o, 0);
    endtask

    vec_t tbl[11];
    vec_t rv;
    logic [1:0] sz;
    int n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //        addr          sig        wd            rdata         dly mis be       wdata         ld
        tbl[0]  = '{32'h10, 6'b001001, 32'h0,        32'h8899AABB, 3, 0, 4'b1111, 32'h0,        32'h8899AABB};
        tbl[1]  = '{32'h13, 6'b000001, 32'h0,        32'h80112233, 1, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{32'h13, 6'b010001, 32'h0,        32'h80112233, 2, 0, 4'b1000, 32'h0,        32'h00000080};
        tbl[3]  = '{32'h22, 6'b000110, 32'h0000BEEF, 32'h0,        2, 0, 4'b1100, 32'hBEEFBEEF, 32'h0};
        tbl[4]  = '{32'h06, 6'b001001, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,        32'h0};
        tbl[5]  = '{32'h05, 6'b000101, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,        32'h0};
        tbl[6]  = '{32'h12, 6'b000101, 32'h0,        32'h80017FFF, 1, 0, 4'b1100, 32'h0,        32'hFFFF8001};
        tbl[7]  = '{32'h31, 6'b000010, 32'h123456A5, 32'h0,        1, 0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        tbl[8]  = '{32'h44, 6'b001011, 32'hDEADBEEF, 32'h0,        2, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[9]  = '{32'h02, 6'b110001, 32'h0,        32'h11C30000, 1, 0, 4'b0100, 32'h0,        32'h000000C3};
        tbl[10] = '{32'h08, 6'b001101, 32'h0,        32'h01234567, 4, 0, 4'b1111, 32'h0,        32'h01234567};

        reset = 1'b1; op_valid = 1'b0; mem_signals = '0; addr = '0; wr_data = '0;
        mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req", mem_bus.mem_req_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_ldata", load_data_o, 0);
        check("rst_lvalid", load_valid_o, 0);
        check("rst_mis", misalign_o, 0);
        check("rst_err", error_o, 0);
        check("rst_be", mem_bus.mem_be_o, 0);
        reset = 1'b0;

        foreach (tbl[i]) run_op(tbl[i]);

        // Stray ack while idle must not produce a load
        @(posedge clock); #1;
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hCAFEF00D;
        @(posedge clock); #1 mem_bus.mem_ack_i = 1'b0;
        @(negedge clock);
        check("stray_ack_lvalid", load_valid_o, 0);
        check("stray_ack_req", mem_bus.mem_req_o, 0);

        for (int i = 0; i < 80; i++) begin
            rv.addr     = $urandom;
            rv.sig      = 6'($urandom);
            rv.wd       = $urandom;
            rv.rdata    = $urandom;
            rv.delay    = $urandom_range(1, 4);
            sz          = rv.sig[3:2];
            rv.mis      = !m_aligned(rv.addr, sz);
            rv.be       = m_be(rv.addr, sz);
            rv.wdata    = m_wdata(rv.wd, sz);
            rv.ld       = m_load(rv.rdata, rv.addr, sz, rv.sig[4]);
            run_op(rv);
        end
        check("no_err_yet", error_o, 0);

        // Timeout: read never acknowledged
        @(posedge clock); #1;
        op_valid = 1'b1; mem_signals = 6'b001001; addr = 32'h40;
        @(negedge clock);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!mem_bus.mem_req_o) break;
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_err", error_o, 1);
        check("timeout_ldata", load_data_o, 0);
        check("timeout_stall", stall_o, 0);
        @(posedge clock); #1 op_valid = 1'b0;
        @(negedge clock);
        check("err_sticky", error_o, 1);
        check("timeout_idle", mem_bus.mem_req_o, 0);
        run_op(tbl[0]);
        check("err_sticky2", error_o, 1);

        // Reset in the middle of an access
        @(posedge clock); #1;
        op_valid = 1'b1; mem_signals = 6'b001010; addr = 32'h50; wr_data = 32'h5555AAAA;
        @(posedge clock); #1;
        @(negedge clock);
        check("pre_rst_req", mem_bus.mem_req_o, 1);
        @(posedge clock); #1 reset = 1'b1; op_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("arst_req", mem_bus.mem_req_o, 0);
        check("arst_we", mem_bus.mem_we_o, 0);
        check("arst_addr", mem_bus.mem_addr_o, 0);
        check("arst_wdata", mem_bus.mem_wdata_o, 0);
        check("arst_stall", stall_o, 0);
        check("arst_lvalid", load_valid_o, 0);
        check("arst_ldata", load_data_o, 0);
        check("arst_err", error_o, 0);
        @(posedge clock); #1 mem_bus.mem_ack_i = 1'b1;
        @(posedge clock); #1 mem_bus.mem_ack_i = 1'b0;
        @(negedge clock);
        check("arst_late_ack", load_valid_o, 0);
        check("arst_idle", mem_bus.mem_req_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
